// File: rtl/seu_harness_pkg.sv
// Shared types and constants for the single-event-upset state harness.
package seu_harness_pkg;

   // Run sequencing: wait in IDLE, count down to the flip, watch the aftermath, report.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      OBSERVE = 2'd2,
      DONE    = 2'd3
   } fsm_t;

   // Classification of a finished run; NONE means no run has completed since arm or reset.
   typedef enum logic [1:0] {
      NONE    = 2'd0,
      MASKED  = 2'd1,
      FAILURE = 2'd2,
      LATENT  = 2'd3
   } result_t;

   // Saturation value for counters; wide enough that any counter width can truncate it.
   localparam logic [63:0] CNT_SAT = '1;

endpackage

// File: rtl/scan_state_reg.sv
// One copy of the harness state register: parallel load with an XOR upset mask, or serial shift.
module scan_state_reg #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic         shift,
   input  logic         sin,
   input  logic [W-1:0] d,
   input  logic [W-1:0] flip,
   output logic [W-1:0] q
);

   // Shift takes priority over load so the scan chain can preload without interference from the cone.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         if (shift) begin
            q <= {q[W-2:0], sin};
         end else if (load) begin
            q <= d ^ flip;
         end
      end
   end

endmodule

// File: rtl/seu_state_harness.sv
// Golden/faulty state harness: injects one bit flip into the faulty copy and classifies the outcome.
module seu_state_harness
   import seu_harness_pkg::*;
#(
   parameter int STATE_W = 6,
   parameter int PO_W    = 19,
   parameter int CNT_W   = 16,
   parameter int OBS_MAX = 1024
) (
   input  logic                       CK,
   input  logic                       CLR,
   input  logic                       en,
   input  logic [STATE_W-1:0]         ns_gold,
   input  logic [STATE_W-1:0]         ns_fault,
   input  logic [PO_W-1:0]            po_gold,
   input  logic [PO_W-1:0]            po_fault,
   output logic [STATE_W-1:0]         state_gold,
   output logic [STATE_W-1:0]         state_fault,
   input  logic                       scan_en,
   input  logic                       scan_in,
   output logic                       scan_out,
   input  logic                       inj_arm,
   input  logic [CNT_W-1:0]           inj_cycle,
   input  logic [$clog2(STATE_W)-1:0] inj_bit,
   output logic                       busy,
   output logic                       done,
   output logic [1:0]                 result,
   output logic                       inj_err,
   output logic [CNT_W-1:0]           mm_cnt,
   output logic [CNT_W-1:0]           first_mm
);

   localparam logic [CNT_W-1:0] SAT      = CNT_W'(CNT_SAT);
   localparam logic [CNT_W-1:0] OBS_LAST = CNT_W'(OBS_MAX - 1);

   fsm_t                       state_q;
   fsm_t                       state_d;
   result_t                    result_q;
   logic [CNT_W-1:0]           cyc;
   logic [CNT_W-1:0]           obs;
   logic [CNT_W-1:0]           inj_cyc_q;
   logic [$clog2(STATE_W)-1:0] inj_bit_q;
   logic                       do_shift;
   logic                       do_arm;
   logic                       do_flip;
   logic                       do_obs;
   logic                       exit_conv;
   logic                       exit_to;
   logic                       po_mis;
   logic                       converged;
   logic                       any_mm;
   logic [STATE_W-1:0]         flip_mask;

   assign po_mis    = (po_gold != po_fault);
   assign converged = (state_gold == state_fault) && !po_mis;
   assign any_mm    = (mm_cnt != '0) || po_mis;
   assign flip_mask = (do_flip && !inj_err) ? (STATE_W'(1) << inj_bit_q) : '0;

   assign busy     = (state_q == ARMED) || (state_q == OBSERVE);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign scan_out = state_fault[STATE_W-1];

   scan_state_reg #(.W(STATE_W)) u_gold (
      .clk   (CK),
      .rst   (CLR),
      .en    (en),
      .load  (1'b1),
      .shift (do_shift),
      .sin   (scan_in),
      .d     (ns_gold),
      .flip  ({STATE_W{1'b0}}),
      .q     (state_gold)
   );

   scan_state_reg #(.W(STATE_W)) u_fault (
      .clk   (CK),
      .rst   (CLR),
      .en    (en),
      .load  (1'b1),
      .shift (do_shift),
      .sin   (scan_in),
      .d     (ns_fault),
      .flip  (flip_mask),
      .q     (state_fault)
   );

   // State register: clear aborts any run, a low enable freezes the sequence.
   always_ff @(posedge CK) begin
      if (CLR) begin
         state_q <= IDLE;
      end else if (en) begin
         state_q <= state_d;
      end
   end

   // Next-state decode and per-cycle strobes for the datapath; scan beats arm when both are requested.
   always_comb begin
      state_d   = state_q;
      do_shift  = 1'b0;
      do_arm    = 1'b0;
      do_flip   = 1'b0;
      do_obs    = 1'b0;
      exit_conv = 1'b0;
      exit_to   = 1'b0;
      case (state_q)
         IDLE: begin
            if (scan_en) begin
               do_shift = 1'b1;
            end else if (inj_arm) begin
               do_arm  = 1'b1;
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (cyc == inj_cyc_q) begin
               do_flip = 1'b1;
               state_d = OBSERVE;
            end
         end
         OBSERVE: begin
            do_obs = 1'b1;
            if (converged) begin
               exit_conv = 1'b1;
               state_d   = DONE;
            end else if (obs == OBS_LAST) begin
               exit_to = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Run bookkeeping: latch the injection request, count cycles, record mismatches and the verdict.
   always_ff @(posedge CK) begin
      if (CLR) begin
         cyc       <= '0;
         obs       <= '0;
         inj_cyc_q <= '0;
         inj_bit_q <= '0;
         inj_err   <= 1'b0;
         mm_cnt    <= '0;
         first_mm  <= SAT;
         result_q  <= NONE;
      end else if (en) begin
         if (do_arm) begin
            inj_cyc_q <= inj_cycle;
            inj_bit_q <= inj_bit;
            inj_err   <= (int'(inj_bit) >= STATE_W);
            cyc       <= '0;
            mm_cnt    <= '0;
            first_mm  <= SAT;
            result_q  <= NONE;
         end
         if (state_q == ARMED) begin
            cyc <= cyc + 1'b1;
            obs <= '0;
         end
         if (do_obs) begin
            obs <= obs + 1'b1;
            if (po_mis) begin
               if (mm_cnt != SAT) begin
                  mm_cnt <= mm_cnt + 1'b1;
               end
               if (mm_cnt == '0) begin
                  first_mm <= obs;
               end
            end
            if (exit_conv) begin
               result_q <= any_mm ? FAILURE : MASKED;
            end else if (exit_to) begin
               result_q <= any_mm ? FAILURE : LATENT;
            end
         end
      end
   end

endmodule

// File: tb/tb_seu_state_harness.sv
// Randomized bench for seu_state_harness with a trajectory-level reference model of each run.
module tb_seu_state_harness;

   logic        CK;
   logic        CLR;
   logic        en;
   logic [5:0]  ns_gold;
   logic [5:0]  ns_fault;
   logic [18:0] po_gold;
   logic [18:0] po_fault;
   logic [5:0]  state_gold;
   logic [5:0]  state_fault;
   logic        scan_en;
   logic        scan_in;
   logic        scan_out;
   logic        inj_arm;
   logic [15:0] inj_cycle;
   logic [2:0]  inj_bit;
   logic        busy;
   logic        done;
   logic [1:0]  result;
   logic        inj_err;
   logic [15:0] mm_cnt;
   logic [15:0] first_mm;

   int          total;
   int          bad;

   int          run_mode;
   logic [5:0]  cone_key;
   logic [5:0]  mod_g;
   logic [5:0]  mod_f;

   logic [5:0]  exp_g[$];
   logic [5:0]  exp_f[$];
   int          e_idx;
   int          exp_mm;
   logic [15:0] exp_fm;
   int          exp_res;
   logic        exp_err;

   seu_state_harness dut (
      .CK          (CK),
      .CLR         (CLR),
      .en          (en),
      .ns_gold     (ns_gold),
      .ns_fault    (ns_fault),
      .po_gold     (po_gold),
      .po_fault    (po_fault),
      .state_gold  (state_gold),
      .state_fault (state_fault),
      .scan_en     (scan_en),
      .scan_in     (scan_in),
      .scan_out    (scan_out),
      .inj_arm     (inj_arm),
      .inj_cycle   (inj_cycle),
      .inj_bit     (inj_bit),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .inj_err     (inj_err),
      .mm_cnt      (mm_cnt),
      .first_mm    (first_mm)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   // Stand-in next-state cone; the same logic serves both copies, only the state differs.
   function automatic logic [5:0] cone_ns(input logic [5:0] s);
      case (run_mode)
         0:       return s;
         1, 2:    return 6'd0;
         3:       return s & cone_key;
         default: return {s[4:0], s[5]};
      endcase
   endfunction

   // Stand-in primary-output cone.
   function automatic logic [18:0] cone_po(input logic [5:0] s);
      case (run_mode)
         0:       return {13'd0, cone_key};
         2:       return 19'h5a5a5;
         3:       return {s, s ^ cone_key, 7'h11};
         default: return {13'd0, s};
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // One clock: cones are driven from the model's idea of the state, then sample after the edge.
   task automatic applyStimulus(input logic e);
      @(negedge CK);
      en       = e;
      ns_gold  = cone_ns(mod_g);
      ns_fault = cone_ns(mod_f);
      po_gold  = cone_po(mod_g);
      po_fault = cone_po(mod_f);
      @(posedge CK);
      #1;
   endtask

   // Expected trajectory of a run, indexed by enabled edges after the arm edge.
   task automatic build_model(input logic [5:0] pre, input int inj, input int bitn);
      logic [5:0] g;
      logic [5:0] f;
      logic [5:0] m;
      logic       mis;
      exp_g.delete();
      exp_f.delete();
      g = cone_ns(pre);
      f = g;
      exp_g.push_back(g);
      exp_f.push_back(f);
      m = (bitn < 6) ? 6'(1 << bitn) : 6'd0;
      for (int c = 0; c <= inj; c++) begin
         g = cone_ns(g);
         f = cone_ns(f) ^ ((c == inj) ? m : 6'd0);
         exp_g.push_back(g);
         exp_f.push_back(f);
      end
      exp_mm  = 0;
      exp_fm  = 16'hffff;
      exp_res = 0;
      for (int o = 0; o < 1024 && exp_res == 0; o++) begin
         mis = (cone_po(g) != cone_po(f));
         if (mis) begin
            if (exp_mm == 0) exp_fm = 16'(o);
            exp_mm++;
         end
         if (g == f && !mis) exp_res = (exp_mm != 0) ? 2 : 1;
         else if (o == 1023) exp_res = (exp_mm != 0) ? 2 : 3;
         g = cone_ns(g);
         f = cone_ns(f);
         exp_g.push_back(g);
         exp_f.push_back(f);
      end
      e_idx = exp_g.size() - 1;
      exp_g.push_back(cone_ns(g));
      exp_f.push_back(cone_ns(f));
      exp_err = (bitn >= 6);
   endtask

   task automatic preload(input logic [5:0] s);
      for (int i = 5; i >= 0; i--) begin
         scan_en = 1'b1;
         scan_in = s[i];
         inj_arm = 1'($urandom_range(0, 1));
         applyStimulus(1'b1);
         mod_g = {mod_g[4:0], s[i]};
         mod_f = {mod_f[4:0], s[i]};
      end
      scan_en = 1'b0;
      inj_arm = 1'b0;
      checkOutput("scan_gold", 32'(state_gold), 32'(s));
      checkOutput("scan_fault", 32'(state_fault), 32'(s));
      checkOutput("scan_out", 32'(scan_out), 32'(s[5]));
      checkOutput("scan_idle", 32'(busy), 32'd0);
   endtask

   task automatic run_one(input int mode, input logic [5:0] key, input logic [5:0] pre, input int inj,
                          input int bitn, input int hold, input logic rand_en, input int abort_at);
      int   idx;
      int   step;
      logic e;
      run_mode = mode;
      cone_key = key;
      preload(pre);
      build_model(pre, inj, bitn);
      inj_arm   = 1'b1;
      inj_cycle = 16'(inj);
      inj_bit   = 3'(bitn);
      applyStimulus(1'b1);
      inj_cycle = 16'($urandom);
      inj_bit   = 3'($urandom);
      idx   = 0;
      step  = 0;
      mod_g = exp_g[0];
      mod_f = exp_f[0];
      checkOutput("arm_busy", 32'(busy), 32'd1);
      checkOutput("arm_result", 32'(result), 32'd0);
      while (idx <= e_idx && step < 4000 && !(abort_at >= 0 && idx == abort_at)) begin
         e = (step < hold) ? 1'b0 : (rand_en ? ($urandom_range(0, 4) != 0) : 1'b1);
         inj_arm = 1'($urandom_range(0, 1));
         scan_en = 1'($urandom_range(0, 1));
         scan_in = 1'($urandom);
         applyStimulus(e);
         if (e) idx++;
         mod_g = exp_g[idx];
         mod_f = exp_f[idx];
         step++;
         checkOutput("run_gold", 32'(state_gold), 32'(exp_g[idx]));
         checkOutput("run_fault", 32'(state_fault), 32'(exp_f[idx]));
         checkOutput("run_busy", 32'(busy), 32'(idx < e_idx));
         checkOutput("run_done", 32'(done), 32'(idx == e_idx));
      end
      inj_arm = 1'b0;
      scan_en = 1'b0;
      if (abort_at < 0) begin
         checkOutput("run_bound", 32'(idx), 32'(e_idx + 1));
         checkOutput("result", 32'(result), 32'(exp_res));
         checkOutput("mm_cnt", 32'(mm_cnt), 32'(exp_mm));
         checkOutput("first_mm", 32'(first_mm), 32'(exp_fm));
         checkOutput("inj_err", 32'(inj_err), 32'(exp_err));
      end else begin
         checkOutput("abort_reached", 32'(idx), 32'(abort_at));
         CLR = 1'b1;
         applyStimulus(1'b0);
         CLR   = 1'b0;
         mod_g = 6'd0;
         mod_f = 6'd0;
         checkOutput("clr_busy", 32'(busy), 32'd0);
         checkOutput("clr_done", 32'(done), 32'd0);
         checkOutput("clr_result", 32'(result), 32'd0);
         checkOutput("clr_first_mm", 32'(first_mm), 32'hffff);
         checkOutput("clr_mm_cnt", 32'(mm_cnt), 32'd0);
         checkOutput("clr_gold", 32'(state_gold), 32'd0);
         checkOutput("clr_fault", 32'(state_fault), 32'd0);
         for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1);
            mod_g = cone_ns(mod_g);
            mod_f = cone_ns(mod_f);
            checkOutput("post_clr_done", 32'(done), 32'd0);
            checkOutput("post_clr_busy", 32'(busy), 32'd0);
            checkOutput("post_clr_gold", 32'(state_gold), 32'(mod_g));
         end
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      run_mode  = 0;
      cone_key  = 6'd0;
      mod_g     = 6'd0;
      mod_f     = 6'd0;
      CLR       = 1'b1;
      en        = 1'b0;
      scan_en   = 1'b0;
      scan_in   = 1'b0;
      inj_arm   = 1'b0;
      inj_cycle = 16'd0;
      inj_bit   = 3'd0;
      ns_gold   = 6'd0;
      ns_fault  = 6'd0;
      po_gold   = 19'd0;
      po_fault  = 19'd0;

      applyStimulus(1'b0);
      applyStimulus(1'b1);
      CLR = 1'b0;
      checkOutput("rst_gold", 32'(state_gold), 32'd0);
      checkOutput("rst_fault", 32'(state_fault), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_result", 32'(result), 32'd0);
      checkOutput("rst_inj_err", 32'(inj_err), 32'd0);
      checkOutput("rst_mm_cnt", 32'(mm_cnt), 32'd0);
      checkOutput("rst_first_mm", 32'(first_mm), 32'hffff);
      checkOutput("rst_scan_out", 32'(scan_out), 32'd0);

      // Identity cones, constant outputs: the flip never heals and never shows.
      run_one(0, 6'h2a, 6'b000101, 3, 1, 0, 1'b0, -1);
      checkOutput("t1_latent", 32'(result), 32'd3);
      // Cones clear the state and expose it on the outputs: one visible mismatch.
      run_one(1, 6'h00, 6'h3f, 0, 5, 0, 1'b0, -1);
      checkOutput("t2_failure", 32'(result), 32'd2);
      checkOutput("t2_mm_cnt", 32'(mm_cnt), 32'd1);
      checkOutput("t2_first_mm", 32'(first_mm), 32'd0);
      // Same state cone, constant outputs: healed without being seen.
      run_one(2, 6'h00, 6'h15, 0, 5, 0, 1'b0, -1);
      checkOutput("t3_masked", 32'(result), 32'd1);
      // Out-of-range bit: no flip at all.
      run_one(1, 6'h00, 6'h2b, 4, 7, 0, 1'b0, -1);
      checkOutput("t4_err", 32'(inj_err), 32'd1);
      checkOutput("t4_masked", 32'(result), 32'd1);
      // Enable held low right after arm delays the flip.
      run_one(3, 6'h00, 6'h11, 4, 2, 5, 1'b0, -1);
      // Clear while observing a persistent upset.
      run_one(4, 6'h00, 6'h01, 2, 0, 0, 1'b1, 6);

      for (int r = 0; r < 8; r++) begin
         run_one(int'($urandom_range(0, 4)), 6'($urandom), 6'($urandom), int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
